// File: rtl/neuron_accumulator_pkg.sv
// Shared float constants and FSM encodings for the neuron accumulator.
// FP_ONE is shared with the sigmoid stage's ONE/TWO constants.
package neuron_accumulator_pkg;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    localparam int LAT_W = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_ACC  = 3'd2;
    localparam logic [2:0] ST_BIAS = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/Fadder_Fsubtractor.sv
// IEEE-754 single add/subtract, round-to-nearest-even, subnormals flushed to zero.
// Latency LAT cycles (LAT-1 registers after the combinational core); no backpressure.
module Fadder_Fsubtractor
    import neuron_accumulator_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result
);

    function automatic logic [31:0] fp_add(input logic [31:0] fa, input logic [31:0] fb);
        logic [31:0] big, sml;
        logic [7:0]  d;
        logic [26:0] mx, my;
        logic        lost;
        logic [27:0] s;
        logic [9:0]  e;
        logic [4:0]  lz;
        logic        found;
        logic [23:0] r;
        logic        sgn;
        if ((fa[30:23] == 8'hFF && fa[22:0] != 0) || (fb[30:23] == 8'hFF && fb[22:0] != 0))
            return FP_QNAN;
        if (fa[30:23] == 8'hFF)
            return (fb[30:23] == 8'hFF && fa[31] != fb[31]) ? FP_QNAN : fa;
        if (fb[30:23] == 8'hFF)
            return fb;
        if (fa[30:23] == 8'h00)
            return (fb[30:23] == 8'h00) ? {fa[31] & fb[31], 31'h0} : fb;
        if (fb[30:23] == 8'h00)
            return fa;
        if (fa[30:0] >= fb[30:0]) begin
            big = fa; sml = fb;
        end else begin
            big = fb; sml = fa;
        end
        sgn = big[31];
        d   = big[30:23] - sml[30:23];
        mx  = {1'b1, big[22:0], 3'b000};
        my  = {1'b1, sml[22:0], 3'b000};
        // Alignment keeps a sticky bit so rounding sees every shifted-out one
        if (d >= 8'd27) begin
            my = 27'd1;
        end else begin
            lost = |(my & ((27'd1 << d) - 27'd1));
            my   = (my >> d) | {26'd0, lost};
        end
        if (big[31] == sml[31]) s = {1'b0, mx} + {1'b0, my};
        else                    s = {1'b0, mx} - {1'b0, my};
        if (s == 28'd0)
            return FP_ZERO;
        e = {2'b00, big[30:23]};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            lz    = '0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (s[i]) found = 1'b1;
                    else      lz    = lz + 5'd1;
                end
            end
            s = s << lz;
            e = e - {5'd0, lz};
        end
        r = {1'b0, s[25:3]} + {23'd0, (s[2] && (s[1] || s[0] || s[3]))};
        if (r[23])
            e = e + 10'd1;
        if (e[9] || e == 10'd0)
            return {sgn, 31'h0};
        if (e >= 10'd255)
            return {sgn, 8'hFF, 23'h0};
        return {sgn, e[7:0], r[22:0]};
    endfunction

    logic [31:0] res_c;
    assign res_c = fp_add(a, {b[31] ^ sub, b[30:0]});

    generate
        if (LAT <= 1) begin : g_comb
            assign result = res_c;
        end else begin : g_pipe
            logic [31:0] pipe [LAT-1];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= res_c;
                    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign result = pipe[LAT-2];
        end
    endgenerate

endmodule

// File: rtl/Fmultiplier.sv
// IEEE-754 single multiply, round-to-nearest-even, subnormals flushed to zero.
// Latency LAT cycles (LAT-1 registers after the combinational core); no backpressure.
module Fmultiplier
    import neuron_accumulator_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    function automatic logic [31:0] fp_mul(input logic [31:0] fa, input logic [31:0] fb);
        logic        sgn;
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        logic        g;
        logic        st;
        logic [23:0] r;
        sgn = fa[31] ^ fb[31];
        if ((fa[30:23] == 8'hFF && fa[22:0] != 0) || (fb[30:23] == 8'hFF && fb[22:0] != 0))
            return FP_QNAN;
        if (fa[30:23] == 8'hFF || fb[30:23] == 8'hFF)
            return (fa[30:23] == 8'h00 || fb[30:23] == 8'h00) ? FP_QNAN : {sgn, 8'hFF, 23'h0};
        if (fa[30:23] == 8'h00 || fb[30:23] == 8'h00)
            return {sgn, 31'h0};
        p = {24'd0, 1'b1, fa[22:0]} * {24'd0, 1'b1, fb[22:0]};
        e = {2'b00, fa[30:23]} + {2'b00, fb[30:23]} - 10'd127;
        if (p[47]) begin
            m  = p[46:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'd1;
        end else begin
            m  = p[45:23];
            g  = p[22];
            st = |p[21:0];
        end
        r = {1'b0, m} + {23'd0, (g && (st || m[0]))};
        if (r[23])
            e = e + 10'd1;
        if (e[9] || e == 10'd0)
            return {sgn, 31'h0};
        if (e >= 10'd255)
            return {sgn, 8'hFF, 23'h0};
        return {sgn, e[7:0], r[22:0]};
    endfunction

    logic [31:0] res_c;
    assign res_c = fp_mul(a, b);

    generate
        if (LAT <= 1) begin : g_comb
            assign result = res_c;
        end else begin : g_pipe
            logic [31:0] pipe [LAT-1];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= res_c;
                    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign result = pipe[LAT-2];
        end
    endgenerate

endmodule

// File: rtl/neuron_accumulator_lat_wait_cnt.sv
// Loadable down-counter timing the multiplier/adder waits; done is high at zero.
// Latency: a load of N gives done N cycles later; no backpressure.
module lat_wait_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            cnt <= '0;
        else if (load)           cnt <= load_val;
        else if (cnt != '0)      cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/neuron_accumulator.sv
// Neuron weighted sum: net = sum(x*w) (+ bias when NEURON_ACC_BIAS_EN is defined).
// Latency: 1+MUL_LAT+ADD_LAT per term, plus ADD_LAT for bias on the last term.
// Backpressure: in_ready only in IDLE; net/out_valid held until out_ready.
module neuron_accumulator
    import neuron_accumulator_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int ADD_LAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    input  logic [31:0]      w,
    input  logic             in_last,
    input  logic [31:0]      bias,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      net,
    output logic [CNT_W-1:0] term_cnt,
    output logic             cnt_ovf
);

    logic [2:0]       state;
    logic [31:0]      x_reg, w_reg, prod_reg, acc;
    logic             last_reg;
    logic [31:0]      mul_res, add_res, add_b;
    logic             accept;
    logic             wc_load, wc_done;
    logic [LAT_W-1:0] wc_val;

`ifdef NEURON_ACC_BIAS_EN
    logic [31:0] bias_reg;
    assign add_b = (state == ST_BIAS) ? bias_reg : prod_reg;
`else
    logic bias_unused;
    assign bias_unused = ^bias;
    assign add_b = prod_reg;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign net       = acc;
    assign accept    = in_valid && in_ready;

    Fmultiplier #(.LAT(MUL_LAT)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (x_reg),
        .b       (w_reg),
        .result  (mul_res)
    );

    Fadder_Fsubtractor #(.LAT(ADD_LAT)) u_add (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (acc),
        .b       (add_b),
        .sub     (1'b0),
        .result  (add_res)
    );

    // Loading LAT-1 makes each wait state last exactly LAT cycles
    always_comb begin
        wc_load = 1'b0;
        wc_val  = '0;
        if (accept) begin
            wc_load = 1'b1;
            wc_val  = LAT_W'(MUL_LAT - 1);
        end else if (state == ST_MUL && wc_done) begin
            wc_load = 1'b1;
            wc_val  = LAT_W'(ADD_LAT - 1);
        end
`ifdef NEURON_ACC_BIAS_EN
        else if (state == ST_ACC && wc_done && last_reg) begin
            wc_load = 1'b1;
            wc_val  = LAT_W'(ADD_LAT - 1);
        end
`endif
    end

    lat_wait_cnt #(.W(LAT_W)) u_wait (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (wc_load),
        .load_val (wc_val),
        .done     (wc_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            x_reg    <= '0;
            w_reg    <= '0;
            last_reg <= 1'b0;
            prod_reg <= '0;
            acc      <= FP_ZERO;
            term_cnt <= '0;
            cnt_ovf  <= 1'b0;
`ifdef NEURON_ACC_BIAS_EN
            bias_reg <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        x_reg    <= x;
                        w_reg    <= w;
                        last_reg <= in_last;
`ifdef NEURON_ACC_BIAS_EN
                        if (in_last) bias_reg <= bias;
`endif
                        if (&term_cnt) cnt_ovf  <= 1'b1;
                        else           term_cnt <= term_cnt + 1'b1;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (wc_done) begin
                        prod_reg <= mul_res;
                        state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (wc_done) begin
                        acc <= add_res;
`ifdef NEURON_ACC_BIAS_EN
                        state <= last_reg ? ST_BIAS : ST_IDLE;
`else
                        state <= last_reg ? ST_DONE : ST_IDLE;
`endif
                    end
                end
`ifdef NEURON_ACC_BIAS_EN
                ST_BIAS: begin
                    if (wc_done) begin
                        acc   <= add_res;
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        acc      <= FP_ZERO;
                        term_cnt <= '0;
                        cnt_ovf  <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed-vector bench for neuron_accumulator (MUL_LAT=2, ADD_LAT=3, CNT_W=2).
// Bias expectations follow NEURON_ACC_BIAS_EN as defined for the build.
module tb_neuron_accumulator;

    localparam int M = 2;
    localparam int A = 3;
`ifdef NEURON_ACC_BIAS_EN
    localparam int LAST_LAT = 1 + M + 2 * A;
`else
    localparam int LAST_LAT = 1 + M + A;
`endif
    localparam int TERM_LAT = 1 + M + A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, cnt_ovf;
    logic [31:0] x, w, bias, net;
    logic [1:0]  term_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    neuron_accumulator #(.MUL_LAT(M), .ADD_LAT(A), .CNT_W(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .net       (net),
        .term_cnt  (term_cnt),
        .cnt_ovf   (cnt_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drives one term; n counts edges from the accept edge until in_ready
    // (non-last) or out_valid (last) is seen.
    task automatic send_term(input logic [31:0] tx, input logic [31:0] tw, input logic tl,
                             input logic [31:0] tbias, output int n);
        @(negedge clk);
        x = tx; w = tw; in_last = tl; bias = tbias; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!(tl ? out_valid : in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic take_output(input string tag, input logic [31:0] exp_net,
                               input logic [1:0] exp_cnt, input logic exp_ovf);
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_net"}, net, exp_net);
        check({tag, "_cnt"}, {30'd0, term_cnt}, {30'd0, exp_cnt});
        check({tag, "_ovf"}, {31'd0, cnt_ovf}, {31'd0, exp_ovf});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_rdy"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_post_cnt"}, {30'd0, term_cnt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tx [4];
        logic [31:0] tw [4];
        logic [31:0] held;
        logic        stable;
        int          n;

        reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        x = '0; w = '0; bias = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_net", net, 32'h0);
        check("rst_term_cnt", {30'd0, term_cnt}, 32'd0);
        check("rst_cnt_ovf", {31'd0, cnt_ovf}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single term 1.0 * 2.0
        send_term(32'h3F800000, 32'h40000000, 1'b1, 32'h0, n);
        check("single_lat", n, LAST_LAT);
        take_output("single", 32'h40000000, 2'd1, 1'b0);

        // Three terms: 1*2 + 0.5*4 + -1*1 = 3.0
        tx[0] = 32'h3F800000; tw[0] = 32'h40000000;
        tx[1] = 32'h3F000000; tw[1] = 32'h40800000;
        tx[2] = 32'hBF800000; tw[2] = 32'h3F800000;
        for (int i = 0; i < 2; i++) begin
            send_term(tx[i], tw[i], 1'b0, 32'h0, n);
            check($sformatf("three_lat%0d", i), n, TERM_LAT);
        end
        check("three_partial", net, 32'h40800000);
        send_term(tx[2], tw[2], 1'b1, 32'h0, n);
        check("three_lat2", n, LAST_LAT);
        take_output("three", 32'h40400000, 2'd3, 1'b0);

        // Bias -0.5 applied only when the bias feature is built in
        send_term(32'h3F800000, 32'h3F800000, 1'b1, 32'hBF000000, n);
        check("bias_lat", n, LAST_LAT);
`ifdef NEURON_ACC_BIAS_EN
        take_output("bias", 32'h3F000000, 2'd1, 1'b0);
`else
        take_output("bias", 32'h3F800000, 2'd1, 1'b0);
`endif

        // Back-pressure in DONE with the next neuron's term already waiting
        send_term(32'h40400000, 32'h3F800000, 1'b1, 32'h0, n);
        check("bp_vld", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        x = 32'h3F800000; w = 32'h3F800000; in_last = 1'b1; bias = 32'h0; in_valid = 1'b1;
        held = net;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (net !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        check("bp_stable", {31'd0, stable}, 32'd1);
        check("bp_net", net, 32'h40400000);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_hs_rdy", {31'd0, in_ready}, 32'd1);
        check("bp_hs_vld", {31'd0, out_valid}, 32'd0);
        check("bp_hs_net", net, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accepted", {31'd0, in_ready}, 32'd0);
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_next_lat", n, LAST_LAT);
        take_output("bp_next", 32'h3F800000, 2'd1, 1'b0);

        // Reset during the multiply wait of term 2
        send_term(32'h40000000, 32'h40000000, 1'b0, 32'h0, n);
        check("rstmid_partial", net, 32'h40800000);
        @(negedge clk);
        x = 32'h40000000; w = 32'h40000000; in_last = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstmid_in_mul", {31'd0, in_ready}, 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstmid_net", net, 32'h0);
        check("rstmid_term_cnt", {30'd0, term_cnt}, 32'd0);
        check("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        send_term(32'h40000000, 32'h40000000, 1'b1, 32'h0, n);
        take_output("rstmid_next", 32'h40800000, 2'd1, 1'b0);

        // Four terms with a 2-bit counter: saturates at 3 and flags overflow
        for (int i = 0; i < 3; i++) begin
            send_term(32'h3F800000, 32'h3F800000, 1'b0, 32'h0, n);
        end
        check("sat_cnt3", {30'd0, term_cnt}, 32'd3);
        check("sat_ovf_before", {31'd0, cnt_ovf}, 32'd0);
        send_term(32'h3F800000, 32'h3F800000, 1'b1, 32'h0, n);
        take_output("sat", 32'h40800000, 2'd3, 1'b1);
        check("sat_ovf_cleared", {31'd0, cnt_ovf}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Floating-point weighted-sum stage for one neuron: accepts a stream of (input, weight) pairs in IEEE-754 single precision, computes Σ xᵢ·wᵢ (+ bias), and presents the net value to the downstream `sigmoid` activation. It processes one term at a time through a single shared multiplier and adder, using a ready/valid handshake on both sides. It sits between the layer's input/weight sequencer and the activation stage.

## Interface
- `MUL_LAT`, 2: cycles from operands applied to the `Fmultiplier` until its result is valid (≥1)
- `ADD_LAT`, 2: cycles from operands applied to the `Fadder_Fsubtractor` until its result is valid (≥1)
- `CNT_W`, 8: width of the term counter
- `clk` in 1: clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: `x`/`w`/`in_last` valid
- `in_ready` out 1: block can accept a term
- `x` in 32: input activation, IEEE-754 single
- `w` in 32: weight, IEEE-754 single
- `in_last` in 1: this term is the final term of the neuron
- `bias` in 32: neuron bias, sampled with the last term (used only under `NEURON_ACC_BIAS_EN`)
- `out_valid` out 1: `net` valid
- `out_ready` in 1: downstream accepts `net`
- `net` out 32: weighted sum, IEEE-754 single
- `term_cnt` out CNT_W: number of terms accumulated into the current or last `net`
- `cnt_ovf` out 1: sticky; more than 2^CNT_W−1 terms seen in the current neuron

## Operation
- FSM states: IDLE, MUL, ACC, BIAS, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, register `x`, `w`, `in_last` (and `bias` when `in_last`=1), then go to MUL. `term_cnt`+1, saturating at all-ones; attempting to increment past saturation sets `cnt_ovf`.
- MUL: operands held stable on the multiplier; wait counter runs MUL_LAT cycles; latch the product, then go to ACC.
- ACC: adder A=acc, B=product; wait ADD_LAT cycles; acc←sum. If the latched `in_last`=0, go to IDLE. Otherwise go to BIAS (macro defined) or DONE.
- BIAS: adder A=acc, B=bias_reg; wait ADD_LAT cycles; acc←sum; go to DONE.
- DONE: `out_valid`=1, `net`=acc, held stable until `out_ready`. On handshake: acc←+0.0 (32'h0), clear `term_cnt` and `cnt_ovf`, go to IDLE.
- First term: acc starts at +0.0, so the first ACC pass yields exactly the product (0 + p = p).
- Single-term neuron (`in_last`=1 on the first term): valid, goes through MUL, ACC, then BIAS or DONE.
- NaN/Inf propagate as the arithmetic units produce them; no special handling here.
- Reset (at any point, including mid-wait): state IDLE, acc=0, all registers 0, wait counter 0; the in-flight term is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `net`=32'h0, `term_cnt`=0, `cnt_ovf`=0.
- Per non-last term: 1 (accept) + MUL_LAT + ADD_LAT cycles, then `in_ready` rises again.
- Last term: accept edge to `out_valid` = 1 + MUL_LAT + ADD_LAT (+ ADD_LAT with bias) cycles.
- `in_ready`=0 in every state except IDLE; `in_valid` with `in_ready`=0 is ignored, and upstream must hold its data.
- `out_valid` holds with stable `net` under back-pressure. `in_ready` returns to 1 the cycle after the output handshake; no new term is accepted in the same cycle as the output handshake.

## Configuration
- `NEURON_ACC_BIAS_EN` defined: BIAS state present; `bias` is sampled with the last term and added. Last-term latency includes the extra ADD_LAT.
- `NEURON_ACC_BIAS_EN` undefined: no BIAS state, `bias` port is unused, and `net` = Σ xᵢ·wᵢ.

## Structure
- Shared package/include: float constants `FP_ZERO` (32'h00000000) and `FP_ONE` (32'h3F800000), shared with `sigmoid`'s ONE/TWO; FSM state encodings.
- Reuse the existing `Fmultiplier` and one `Fadder_Fsubtractor` instance. The adder B-input is muxed between product and bias.
- One natural sub-module: `lat_wait_cnt`, a loadable down-counter with a `done` pulse, shared by the MUL/ACC/BIAS waits.

## Test plan
- Single term x=0x3F800000 (1.0), w=0x40000000 (2.0), last=1, no bias: `net`=0x40000000, `term_cnt`=1, `out_valid` after 1+MUL_LAT+ADD_LAT cycles.
- Three terms (1.0·2.0, 0.5·4.0, −1.0·1.0): `net`=0x40400000 (3.0), `term_cnt`=3; `in_ready` is low for MUL_LAT+ADD_LAT cycles after each accept.
- With `NEURON_ACC_BIAS_EN`, x=1.0, w=1.0, bias=0xBF000000 (−0.5): `net`=0x3F000000 (0.5), latency includes an extra ADD_LAT.
- Hold `out_ready`=0 for 10 cycles in DONE: `net` stays stable and `in_ready`=0. After the handshake, the next neuron starts from acc=0 (1.0·1.0 → 0x3F800000).
- Assert `reset_n`=0 during the MUL wait of term 2: outputs return to reset values immediately. The next neuron, 2.0·2.0, gives 0x40800000.
- CNT_W=2, four terms: `term_cnt` saturates at 3 and `cnt_ovf`=1 until the output handshake.
